lcd_hd44780_sequencer: RTL and testbench
========================================

Name: lcd_hd44780_sequencer

Overview:
Memory-mapped HD44780 4-bit LCD write sequencer for the picmicro midrange core on DE2-115. Firmware writes a full command or data byte through the external-peripheral decoder. The block emits high nibble then low nibble with correctly timed EN pulses and post-write delays, replacing PORTB bit-banging. A status byte exposes busy and overrun; a one-cycle done strobe feeds the core's interrupt strobe vector.

Parameters:
SETUP_CYCLES, 4, clocks RS/DATA stable with EN low before each EN rise (≥1)
EN_HIGH_CYCLES, 25, clocks EN held high per nibble (≥1)
HOLD_CYCLES, 25, clocks RS/DATA held after EN fall (≥1)
GAP_CYCLES, 50, clocks between high-nibble hold end and low-nibble setup start (≥1)
CMD_WAIT_CYCLES, 2500, post-transfer wait for normal commands and data (≥1)
SLOW_WAIT_CYCLES, 82000, post-transfer wait when cmd byte[7:2]==0 (clear/home) (≥1)
CNT_WIDTH, 17, phase counter width; must hold the largest cycle parameter

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  synchronous active-low reset
cmd_wr_en  in  1  write wr_data as command (RS=0), both nibbles
data_wr_en  in  1  write wr_data as data (RS=1), both nibbles
nib_wr_en  in  1  write wr_data[7:4] only, RS=0, for the init function-set sequence
wr_data  in  8  byte from extern_peripherals_data_in
status_rd_en  in  1  one-cycle pulse when core reads the status address
status  out  8  {busy, ovr, 6'b0}
done_strobe  out  1  one-cycle pulse at transfer completion
lcd_data  out  4  nibble to LCD D7..D4
lcd_rs  out  1  register select
lcd_rw  out  1  constant 0 (write-only)
lcd_en  out  1  enable strobe

Behaviour:
- Reset (rst_n low at clk edge): state IDLE; lcd_en=0, lcd_data=0, lcd_rs=0, busy=0, ovr=0, done_strobe=0. Reset mid-transfer aborts it: lcd_en falls on that same edge, no done_strobe.
- States: IDLE, SETUP_H, EN_H, HOLD_H, GAP, SETUP_L, EN_L, HOLD_L, WAIT. Each non-IDLE state lasts exactly its parameter count, via a down-counter loaded on entry.
- Accept: in IDLE, any write strobe latches the byte, RS and mode. The next cycle is the first SETUP_H cycle. busy is 1 from that cycle until the WAIT exit.
- Priority for simultaneous strobes: cmd_wr_en > data_wr_en > nib_wr_en. The losers are discarded and do not set ovr.
- Any write strobe while busy=1 is dropped; it sets ovr=1.
- ovr is sticky. It clears on status_rd_en, but a write dropped in the same cycle as the read wins, leaving ovr=1.
- High-nibble path: SETUP_H → EN_H → HOLD_H.
  - lcd_data=byte[7:4] from SETUP_H entry.
  - lcd_en=1 only in EN_H.
- After HOLD_H:
  - Nibble mode goes to WAIT.
  - Byte mode goes GAP → SETUP_L → EN_L → HOLD_L → WAIT, with lcd_data=byte[3:0] from SETUP_L entry.
- lcd_rs is driven from the latched RS for the whole transfer. lcd_rs and lcd_data hold their last values in IDLE.
- WAIT length:
  - SLOW_WAIT_CYCLES when the transfer is a command and byte[7:2]==0.
  - Otherwise CMD_WAIT_CYCLES, including data writes and nibble mode.
- WAIT exit: on the final WAIT cycle edge the block returns to IDLE. In that same cycle busy goes to 0 and done_strobe pulses for exactly one cycle.
- A write strobe in the first IDLE cycle is accepted (back-to-back, no bubble).
- Total busy cycles:
  - Byte: S+E+H+G+S+E+H+W.
  - Nibble: S+E+H+W.
- lcd_en is glitch-free and registered. It never rises without ≥SETUP_CYCLES of stable data before it.
- All outputs are registered.

Test Plan:
Test overrides: S=2, E=3, H=3, G=4, CMD_WAIT=10, SLOW_WAIT=20.
- Reset, then data_wr_en with wr_data=0x41 → lcd_rs=1 throughout.
  - First lcd_en pulse: 3 cycles with lcd_data=4, rising 2 cycles after busy.
  - Second lcd_en pulse: 3 cycles with lcd_data=1.
  - busy high 30 cycles; done_strobe one pulse as busy falls.
- cmd_wr_en with 0x01 → lcd_rs=0, nibbles 0 then 1, busy 40 cycles. cmd 0x28 → busy 30 cycles.
- nib_wr_en with 0x30 → single 3-cycle lcd_en pulse, lcd_data=3, busy 18 cycles, then status=0x00.
- cmd_wr_en 0x0C, then data_wr_en 0x55 five cycles later → second write dropped, status=0xC0. status_rd_en after done → status=0x00. A write in the first IDLE cycle after done starts immediately.
- cmd_wr_en and data_wr_en in the same cycle with 0x80 → command transfer (lcd_rs=0), ovr stays 0.
- rst_n low during EN_L → next edge lcd_en=0, status=0x00, no done_strobe. A new write after reset completes normally.

Source files
------------

// File: rtl/lcd_hd44780_sequencer.sv
// HD44780 4-bit write sequencer: takes a command/data byte (or a lone init nibble)
// and plays it out on D7..D4 with timed EN pulses, hold, gap and post-write wait.
module lcd_hd44780_sequencer #(
    parameter int SETUP_CYCLES     = 4,
    parameter int EN_HIGH_CYCLES   = 25,
    parameter int HOLD_CYCLES      = 25,
    parameter int GAP_CYCLES       = 50,
    parameter int CMD_WAIT_CYCLES  = 2500,
    parameter int SLOW_WAIT_CYCLES = 82000,
    parameter int CNT_WIDTH        = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_wr_en,
    input  logic       data_wr_en,
    input  logic       nib_wr_en,
    input  logic [7:0] wr_data,
    input  logic       status_rd_en,
    output logic [7:0] status,
    output logic       done_strobe,
    output logic [3:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);

    typedef enum logic [3:0] {
        IDLE, SETUP_H, EN_H, HOLD_H, GAP, SETUP_L, EN_L, HOLD_L, WAIT
    } state_t;

    // Counter load values: each phase lasts exactly N cycles, counting N-1 down to 0.
    localparam logic [CNT_WIDTH-1:0] LD_SETUP = CNT_WIDTH'(SETUP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LD_EN    = CNT_WIDTH'(EN_HIGH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LD_HOLD  = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LD_GAP   = CNT_WIDTH'(GAP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LD_CMD   = CNT_WIDTH'(CMD_WAIT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LD_SLOW  = CNT_WIDTH'(SLOW_WAIT_CYCLES - 1);

    state_t               state, state_nx;
    logic [CNT_WIDTH-1:0] cnt, cnt_nx;
    logic [3:0]           lo_q, lo_nx;
    logic                 nib_q, nib_nx;
    logic                 slow_q, slow_nx;
    logic                 busy, busy_nx;
    logic                 ovr, ovr_nx;
    logic                 en_nx, done_nx, rs_nx;
    logic [3:0]           data_nx;
    logic                 any_wr, last;
    logic [CNT_WIDTH-1:0] ld_wait;

    assign any_wr  = cmd_wr_en | data_wr_en | nib_wr_en;
    assign last    = (cnt == '0);
    assign ld_wait = slow_q ? LD_SLOW : LD_CMD;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt - CNT_WIDTH'(1);
        lo_nx    = lo_q;
        nib_nx   = nib_q;
        slow_nx  = slow_q;
        rs_nx    = lcd_rs;
        data_nx  = lcd_data;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (any_wr) begin
                    state_nx = SETUP_H;
                    cnt_nx   = LD_SETUP;
                    lo_nx    = wr_data[3:0];
                    data_nx  = wr_data[7:4];
                    // cmd wins over data, data over nibble
                    rs_nx    = ~cmd_wr_en & data_wr_en;
                    nib_nx   = ~cmd_wr_en & ~data_wr_en;
                    slow_nx  = cmd_wr_en & (wr_data[7:2] == 6'd0);
                end
            end
            SETUP_H: if (last) begin state_nx = EN_H;   cnt_nx = LD_EN;   end
            EN_H:    if (last) begin state_nx = HOLD_H; cnt_nx = LD_HOLD; end
            HOLD_H: begin
                if (last) begin
                    if (nib_q) begin
                        state_nx = WAIT;
                        cnt_nx   = ld_wait;
                    end else begin
                        state_nx = GAP;
                        cnt_nx   = LD_GAP;
                    end
                end
            end
            GAP: begin
                if (last) begin
                    state_nx = SETUP_L;
                    cnt_nx   = LD_SETUP;
                    data_nx  = lo_q;
                end
            end
            SETUP_L: if (last) begin state_nx = EN_L;   cnt_nx = LD_EN;   end
            EN_L:    if (last) begin state_nx = HOLD_L; cnt_nx = LD_HOLD; end
            HOLD_L:  if (last) begin state_nx = WAIT;   cnt_nx = ld_wait; end
            WAIT:    if (last) begin state_nx = IDLE;   cnt_nx = '0;      end
            default: begin state_nx = IDLE; cnt_nx = '0; end
        endcase

        // Outputs are computed from the next state so the registers line up with it.
        en_nx   = (state_nx == EN_H) || (state_nx == EN_L);
        busy_nx = (state_nx != IDLE);
        done_nx = (state == WAIT) && last;
        // A dropped write in the same cycle as a status read keeps ovr set.
        ovr_nx  = (busy & any_wr) ? 1'b1 : (status_rd_en ? 1'b0 : ovr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            lo_q        <= '0;
            nib_q       <= 1'b0;
            slow_q      <= 1'b0;
            busy        <= 1'b0;
            ovr         <= 1'b0;
            lcd_en      <= 1'b0;
            lcd_data    <= '0;
            lcd_rs      <= 1'b0;
            done_strobe <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            lo_q        <= lo_nx;
            nib_q       <= nib_nx;
            slow_q      <= slow_nx;
            busy        <= busy_nx;
            ovr         <= ovr_nx;
            lcd_en      <= en_nx;
            lcd_data    <= data_nx;
            lcd_rs      <= rs_nx;
            done_strobe <= done_nx;
        end
    end

    assign status = {busy, ovr, 6'b0};
    assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_hd44780_sequencer.sv
// Bench for lcd_hd44780_sequencer: EN pulses and busy lengths go through a scoreboard,
// status/reset/priority behaviour is checked inline by each scenario task.
module tb_lcd_hd44780_sequencer;

    localparam int S = 2, E = 3, H = 3, G = 4, W = 10, SW = 20;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       cmd_wr_en = 1'b0, data_wr_en = 1'b0, nib_wr_en = 1'b0, status_rd_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] status;
    logic       done_strobe, lcd_rs, lcd_rw, lcd_en;
    logic [3:0] lcd_data;

    always #10 clk = ~clk;

    lcd_hd44780_sequencer #(
        .SETUP_CYCLES(S), .EN_HIGH_CYCLES(E), .HOLD_CYCLES(H), .GAP_CYCLES(G),
        .CMD_WAIT_CYCLES(W), .SLOW_WAIT_CYCLES(SW), .CNT_WIDTH(17)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_wr_en(cmd_wr_en), .data_wr_en(data_wr_en),
        .nib_wr_en(nib_wr_en), .wr_data(wr_data), .status_rd_en(status_rd_en),
        .status(status), .done_strobe(done_strobe), .lcd_data(lcd_data),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en)
    );

    typedef struct packed {
        logic       rs;
        logic [3:0] d;
        logic [7:0] w;
        logic [7:0] off;
    } pulse_t;

    pulse_t exp_p[$];
    int     exp_busy[$];
    int     n_cmp = 0, n_err = 0, done_cnt = 0;
    bit     sb_off = 1'b0;

    // Scoreboard monitor, sampling on the falling edge.
    pulse_t     cur;
    bit         stable;
    int         bcnt = 0, stab = 0;
    logic       busy_q = 1'b0, en_q = 1'b0, done_q = 1'b0;
    logic [4:0] last_out = 5'h0;

    always @(negedge clk) begin : mon
        logic   busy_s;
        int     eb;
        pulse_t e;
        busy_s = status[7];
        if (busy_s && !busy_q) bcnt = 1;
        else if (busy_s) bcnt = bcnt + 1;

        if (lcd_en && !en_q) begin
            cur    = '{lcd_rs, lcd_data, 8'd1, 8'(bcnt - 1)};
            stable = 1'b1;
            if (!sb_off) begin
                n_cmp++;
                if (stab < S) begin
                    n_err++;
                    $display("FAIL setup_before_en: stable %0d cycles, required >= %0d", stab, S);
                end
            end
        end else if (lcd_en) begin
            cur.w = cur.w + 8'd1;
            if ({lcd_rs, lcd_data} !== {cur.rs, cur.d}) stable = 1'b0;
        end else if (en_q && !sb_off) begin
            n_cmp++;
            if (exp_p.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: got rs=%0d d=%h w=%0d, expected none", cur.rs, cur.d, cur.w);
            end else begin
                e = exp_p.pop_front();
                if (cur !== e || !stable) begin
                    n_err++;
                    $display("FAIL en_pulse: got rs=%0d d=%h w=%0d off=%0d stable=%0d, expected rs=%0d d=%h w=%0d off=%0d stable=1",
                             cur.rs, cur.d, cur.w, cur.off, stable, e.rs, e.d, e.w, e.off);
                end
            end
        end

        if (lcd_en) stab = 0;
        else stab = ({lcd_rs, lcd_data} === last_out) ? stab + 1 : 1;
        last_out = {lcd_rs, lcd_data};

        if (done_strobe) begin
            done_cnt++;
            if (!sb_off) begin
                n_cmp++;
                if (exp_busy.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: got done after %0d busy cycles, expected none", bcnt);
                end else begin
                    eb = exp_busy.pop_front();
                    if (bcnt != eb || !busy_q || busy_s || done_q) begin
                        n_err++;
                        $display("FAIL busy_len: got %0d cycles (busy_fell=%0d done_prev=%0d), expected %0d cycles with busy_fell=1 done_prev=0",
                                 bcnt, busy_q & ~busy_s, done_q, eb);
                    end
                end
            end
        end
        busy_q = busy_s;
        en_q   = lcd_en;
        done_q = done_strobe;
    end

    task automatic drive(input logic c, input logic d, input logic n, input logic [7:0] v);
        cmd_wr_en = c; data_wr_en = d; nib_wr_en = n; wr_data = v;
        @(posedge clk); #1;
        cmd_wr_en = 1'b0; data_wr_en = 1'b0; nib_wr_en = 1'b0;
    endtask

    task automatic expect_byte(input logic rs, input logic [7:0] v, input int wt);
        exp_p.push_back('{rs, v[7:4], 8'(E), 8'(S)});
        exp_p.push_back('{rs, v[3:0], 8'(E), 8'(S + E + H + G + S)});
        exp_busy.push_back(2 * (S + E + H) + G + wt);
    endtask

    task automatic expect_nib(input logic [7:0] v);
        exp_p.push_back('{1'b0, v[7:4], 8'(E), 8'(S)});
        exp_busy.push_back(S + E + H + W);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done_cnt != d0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (lcd_en !== 1'b0 || lcd_rw !== 1'b0) begin n_err++; $display("FAIL reset_en_rw: got en=%b rw=%b, expected 0 0", lcd_en, lcd_rw); end
        n_cmp++;
        if (lcd_data !== 4'h0 || lcd_rs !== 1'b0) begin n_err++; $display("FAIL reset_data_rs: got %h/%b, expected 0/0", lcd_data, lcd_rs); end
        n_cmp++;
        if (status !== 8'h00 || done_strobe !== 1'b0) begin n_err++; $display("FAIL reset_status: got %h done=%b, expected 00 done=0", status, done_strobe); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_data_write;
        bit ok;
        @(posedge clk); #1;
        expect_byte(1'b1, 8'h41, W);
        drive(1'b0, 1'b1, 1'b0, 8'h41);
        n_cmp++;
        if (status !== 8'h80) begin n_err++; $display("FAIL data_busy_start: got %h, expected 80", status); end
        wait_done(200, ok);
        n_cmp++;
        if (!ok || exp_p.size() != 0 || exp_busy.size() != 0) begin
            n_err++; $display("FAIL data_complete: done=%0d pending_pulses=%0d pending_busy=%0d, expected 1/0/0", ok, exp_p.size(), exp_busy.size());
        end
        n_cmp++;
        if ({lcd_rs, lcd_data} !== 5'b1_0001 || status !== 8'h00) begin
            n_err++; $display("FAIL data_idle_hold: got rs=%b d=%h status=%h, expected 1 1 00", lcd_rs, lcd_data, status);
        end
    endtask

    task automatic test_wait_select;
        logic [8:0] tbl [5];
        int         wt  [5];
        bit         ok;
        tbl = '{9'h001, 9'h028, 9'h003, 9'h004, 9'h101};
        wt  = '{SW, W, SW, W, W};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            expect_byte(tbl[i][8], tbl[i][7:0], wt[i]);
            drive(~tbl[i][8], tbl[i][8], 1'b0, tbl[i][7:0]);
            wait_done(200, ok);
            n_cmp++;
            if (!ok || exp_p.size() != 0 || exp_busy.size() != 0) begin
                n_err++; $display("FAIL wait_sel_%0d: done=%0d pending=%0d/%0d, expected 1/0/0", i, ok, exp_p.size(), exp_busy.size());
            end
        end
    endtask

    task automatic test_nibble;
        bit ok;
        @(posedge clk); #1;
        expect_nib(8'h30);
        drive(1'b0, 1'b0, 1'b1, 8'h30);
        wait_done(200, ok);
        n_cmp++;
        if (!ok || exp_p.size() != 0 || exp_busy.size() != 0) begin
            n_err++; $display("FAIL nibble_complete: done=%0d pending=%0d/%0d, expected 1/0/0", ok, exp_p.size(), exp_busy.size());
        end
        n_cmp++;
        if (status !== 8'h00 || lcd_rs !== 1'b0 || lcd_data !== 4'h3) begin
            n_err++; $display("FAIL nibble_status: got status=%h rs=%b d=%h, expected 00 0 3", status, lcd_rs, lcd_data);
        end
    endtask

    task automatic test_overrun;
        bit ok;
        @(posedge clk); #1;
        expect_byte(1'b0, 8'h0C, W);
        drive(1'b1, 1'b0, 1'b0, 8'h0C);
        repeat (4) @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 1'b0, 8'h55);
        n_cmp++;
        if (status !== 8'hC0) begin n_err++; $display("FAIL ovr_set: got %h, expected C0", status); end
        status_rd_en = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 8'h55);
        status_rd_en = 1'b0;
        n_cmp++;
        if (status !== 8'hC0) begin n_err++; $display("FAIL ovr_read_vs_drop: got %h, expected C0", status); end
        status_rd_en = 1'b1;
        @(posedge clk); #1;
        status_rd_en = 1'b0;
        n_cmp++;
        if (status !== 8'h80) begin n_err++; $display("FAIL ovr_clear_busy: got %h, expected 80", status); end
        drive(1'b0, 1'b0, 1'b1, 8'h66);
        wait_done(200, ok);
        n_cmp++;
        if (!ok || exp_p.size() != 0 || status !== 8'h40) begin
            n_err++; $display("FAIL ovr_after_done: done=%0d pending=%0d status=%h, expected 1 0 40", ok, exp_p.size(), status);
        end
        status_rd_en = 1'b1;
        @(posedge clk); #1;
        status_rd_en = 1'b0;
        n_cmp++;
        if (status !== 8'h00) begin n_err++; $display("FAIL ovr_read_clear: got %h, expected 00", status); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        @(posedge clk); #1;
        expect_byte(1'b0, 8'h06, W);
        drive(1'b1, 1'b0, 1'b0, 8'h06);
        wait_done(200, ok);
        // first IDLE cycle: issue the next write right now
        expect_byte(1'b1, 8'h5A, W);
        drive(1'b0, 1'b1, 1'b0, 8'h5A);
        n_cmp++;
        if (!ok || status !== 8'h80) begin n_err++; $display("FAIL b2b_accept: done=%0d status=%h, expected 1 80", ok, status); end
        wait_done(200, ok);
        n_cmp++;
        if (!ok || exp_p.size() != 0 || exp_busy.size() != 0) begin
            n_err++; $display("FAIL b2b_complete: done=%0d pending=%0d/%0d, expected 1/0/0", ok, exp_p.size(), exp_busy.size());
        end
    endtask

    task automatic test_priority;
        bit ok;
        @(posedge clk); #1;
        expect_byte(1'b0, 8'h80, W);
        drive(1'b1, 1'b1, 1'b0, 8'h80);
        n_cmp++;
        if (status !== 8'h80) begin n_err++; $display("FAIL prio_cmd_data_status: got %h, expected 80", status); end
        wait_done(200, ok);
        @(posedge clk); #1;
        expect_byte(1'b1, 8'h37, W);
        drive(1'b0, 1'b1, 1'b1, 8'h37);
        n_cmp++;
        if (status !== 8'h80) begin n_err++; $display("FAIL prio_data_nib_status: got %h, expected 80", status); end
        wait_done(200, ok);
        n_cmp++;
        if (!ok || exp_p.size() != 0 || exp_busy.size() != 0) begin
            n_err++; $display("FAIL prio_complete: done=%0d pending=%0d/%0d, expected 1/0/0", ok, exp_p.size(), exp_busy.size());
        end
    endtask

    task automatic test_reset_mid;
        int d0;
        bit ok;
        sb_off = 1'b1;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 8'h41);
        repeat (S + E + H + G + S) @(posedge clk);
        #1;
        n_cmp++;
        if (lcd_en !== 1'b1 || lcd_data !== 4'h1) begin n_err++; $display("FAIL mid_in_en_l: got en=%b d=%h, expected 1 1", lcd_en, lcd_data); end
        d0 = done_cnt;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (lcd_en !== 1'b0 || status !== 8'h00 || done_strobe !== 1'b0) begin
            n_err++; $display("FAIL mid_reset: got en=%b status=%h done=%b, expected 0 00 0", lcd_en, status, done_strobe);
        end
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        n_cmp++;
        if (done_cnt != d0) begin n_err++; $display("FAIL mid_no_done: got %0d done pulses, expected 0", done_cnt - d0); end
        sb_off = 1'b0;
        expect_byte(1'b1, 8'h41, W);
        drive(1'b0, 1'b1, 1'b0, 8'h41);
        wait_done(200, ok);
        n_cmp++;
        if (!ok || exp_p.size() != 0 || exp_busy.size() != 0) begin
            n_err++; $display("FAIL mid_recover: done=%0d pending=%0d/%0d, expected 1/0/0", ok, exp_p.size(), exp_busy.size());
        end
    endtask

    initial begin
        test_reset;
        test_data_write;
        test_wait_select;
        test_nibble;
        test_overrun;
        test_back_to_back;
        test_priority;
        test_reset_mid;
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
